// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory: reads a 16-bit word count, then packs
// little-endian bytes into 32-bit words and writes them at consecutive word addresses.
module instr_mem_loader #(
    parameter int               Width    = 32,
    parameter int               Depth    = 512,
    parameter logic [Width-1:0] BaseAddr = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte_data,
    output logic             o_byte_ready,
    output logic             o_wr_en,
    output logic [Width-1:0] o_wr_addr,
    output logic [Width-1:0] o_wr_data,
    output logic             o_cpu_hold,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error
);

    localparam logic [15:0] MaxWords = 16'(Depth / 4);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t           r_state;
    logic [7:0]       r_lenLo;
    logic [15:0]      r_wordsLeft;
    logic [1:0]       r_byteIdx;
    logic [Width-1:0] r_word;
    logic [Width-1:0] r_wrAddr;
    logic             r_byteReady;
    logic             r_wrEn;
    logic             r_cpuHold;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic             w_xfer;
    logic [15:0]      w_lenFull;

    assign w_xfer    = i_byte_valid & r_byteReady;
    assign w_lenFull = {i_byte_data, r_lenLo};

    assign o_byte_ready = r_byteReady;
    assign o_wr_en      = r_wrEn;
    assign o_wr_addr    = r_wrAddr;
    assign o_wr_data    = r_word;
    assign o_cpu_hold   = r_cpuHold;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;

    // Outputs are updated on the edge that enters a state, so they are valid for the
    // whole time the FSM sits in that state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_lenLo     <= '0;
            r_wordsLeft <= '0;
            r_byteIdx   <= '0;
            r_word      <= '0;
            r_wrAddr    <= BaseAddr;
            r_byteReady <= 1'b0;
            r_wrEn      <= 1'b0;
            r_cpuHold   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state     <= LEN0;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_cpuHold   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_byteReady <= 1'b1;
                    end
                end
                LEN0: begin
                    if (w_xfer) begin
                        r_lenLo <= i_byte_data;
                        r_state <= LEN1;
                    end
                end
                LEN1: begin
                    if (w_xfer) begin
                        if (w_lenFull == 16'd0) begin
                            r_state     <= DONE;
                            r_byteReady <= 1'b0;
                            r_done      <= 1'b1;
                            r_cpuHold   <= 1'b0;
                        end else if (w_lenFull > MaxWords) begin
                            r_state     <= ERR;
                            r_byteReady <= 1'b0;
                            r_error     <= 1'b1;
                        end else begin
                            r_state     <= DATA;
                            r_byteIdx   <= '0;
                            r_wrAddr    <= BaseAddr;
                            r_wordsLeft <= w_lenFull;
                        end
                    end
                end
                DATA: begin
                    if (w_xfer) begin
                        r_word[8*r_byteIdx +: 8] <= i_byte_data;
                        r_byteIdx                <= r_byteIdx + 2'd1;
                        if (r_byteIdx == 2'd3) begin
                            r_state     <= WRITE;
                            r_byteReady <= 1'b0;
                            r_wrEn      <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    r_wrEn      <= 1'b0;
                    r_wrAddr    <= r_wrAddr + Width'(4);
                    r_wordsLeft <= r_wordsLeft - 16'd1;
                    if (r_wordsLeft == 16'd1) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_cpuHold <= 1'b0;
                    end else begin
                        r_state     <= DATA;
                        r_byteIdx   <= '0;
                        r_byteReady <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                ERR: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: random program images streamed with random
// gaps, compared against an expected write list built from the image contents.
module tb_instr_mem_loader;

    localparam int          Width    = 32;
    localparam int          Depth    = 512;
    localparam logic [31:0] BaseAddr = 32'h0;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte_data = 8'h00;
    logic        o_byte_ready;
    logic        o_wr_en;
    logic [31:0] o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_cpu_hold;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] img[$];
    logic [31:0] wrAddrQ[$];
    logic [31:0] wrDataQ[$];

    instr_mem_loader #(
        .Width(Width),
        .Depth(Depth),
        .BaseAddr(BaseAddr)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_start(i_start),
        .i_byte_valid(i_byte_valid),
        .i_byte_data(i_byte_data),
        .o_byte_ready(o_byte_ready),
        .o_wr_en(o_wr_en),
        .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data),
        .o_cpu_hold(o_cpu_hold),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    // Every cycle with the write strobe high is logged; the list is compared afterwards.
    always @(negedge i_clk) begin
        if (o_wr_en === 1'b1) begin
            wrAddrQ.push_back(o_wr_addr);
            wrDataQ.push_back(o_wr_data);
        end
    end

    task automatic pulseStart();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Offers one byte after a random idle gap and holds it until the loader takes it.
    task automatic sendByte(input logic [7:0] b, input int gapMax, output bit ok);
        int gap;
        int n;
        gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
        repeat (gap) @(negedge i_clk);
        i_byte_valid = 1'b1;
        i_byte_data  = b;
        n = 0;
        while (o_byte_ready !== 1'b1 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        ok = (o_byte_ready === 1'b1);
        @(posedge i_clk);
        #1;
        i_byte_valid = 1'b0;
        i_byte_data  = 8'($urandom);
        @(negedge i_clk);
    endtask

    task automatic loadImage(input logic [15:0] len, input int gapMax, input int startAfter,
                             output bit ok);
        bit okB;
        int idx;
        ok = 1'b1;
        sendByte(len[7:0], gapMax, okB);
        ok &= okB;
        sendByte(len[15:8], gapMax, okB);
        ok &= okB;
        idx = 0;
        foreach (img[w]) begin
            for (int k = 0; k < 4; k++) begin
                sendByte(8'(img[w] >> (8 * k)), gapMax, okB);
                ok &= okB;
                if (idx == startAfter) pulseStart();
                idx++;
            end
        end
    endtask

    task automatic waitFinish(output bit ok);
        int n;
        n = 0;
        while (!(o_done === 1'b1 || o_error === 1'b1) && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        ok = (o_done === 1'b1 || o_error === 1'b1);
    endtask

    task automatic test_reset();
        bit ok;
        checks++;
        if ({o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_cpu_hold, o_busy, o_done, o_error} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_init outputs=%h required 0",
                     {o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_cpu_hold, o_busy, o_done, o_error});
        end
        img = {32'h11223344, 32'h55667788};
        pulseStart();
        sendByte(8'h02, 0, ok);
        sendByte(8'h00, 0, ok);
        sendByte(8'h44, 0, ok);
        sendByte(8'h33, 0, ok);
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_cpu_hold, o_busy, o_done, o_error} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_async outputs=%h required 0",
                     {o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_cpu_hold, o_busy, o_done, o_error});
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        wrAddrQ.delete();
        wrDataQ.delete();
        i_byte_valid = 1'b1;
        i_byte_data  = 8'h22;
        repeat (6) begin
            @(negedge i_clk);
            checks++;
            if (o_byte_ready !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle ready=%b busy=%b required 0 0", o_byte_ready, o_busy);
            end
        end
        i_byte_valid = 1'b0;
        checks++;
        if (wrAddrQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL reset_nowrite writes=%0d required 0", wrAddrQ.size());
        end
    endtask

    // Streams the image in img and checks the write list plus the end-of-load flags.
    task automatic test_load(input string name, input int gapMax, input int startAfter);
        bit ok;
        bit okDone;
        wrAddrQ.delete();
        wrDataQ.delete();
        pulseStart();
        checks++;
        if (o_cpu_hold !== 1'b1 || o_busy !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_start hold=%b busy=%b done=%b required 1 1 0",
                     name, o_cpu_hold, o_busy, o_done);
        end
        loadImage(16'(img.size()), gapMax, startAfter, ok);
        waitFinish(okDone);
        checks++;
        if (!ok || !okDone || o_done !== 1'b1 || o_error !== 1'b0 || o_cpu_hold !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_done accepted=%b finished=%b done=%b error=%b hold=%b required 1 1 1 0 0",
                     name, ok, okDone, o_done, o_error, o_cpu_hold);
        end
        checks++;
        if (wrAddrQ.size() != img.size()) begin
            errors++;
            $display("[TB] FAIL %s_count writes=%0d required %0d", name, wrAddrQ.size(), img.size());
        end
        for (int i = 0; i < img.size() && i < wrAddrQ.size(); i++) begin
            checks++;
            if (wrAddrQ[i] !== BaseAddr + 32'(4 * i) || wrDataQ[i] !== img[i]) begin
                errors++;
                $display("[TB] FAIL %s_word%0d addr=%h data=%h required %h %h", name, i,
                         wrAddrQ[i], wrDataQ[i], BaseAddr + 32'(4 * i), img[i]);
            end
        end
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_idle busy=%b done=%b required 0 1", name, o_busy, o_done);
        end
    endtask

    task automatic test_length_error();
        bit ok;
        bit okB;
        wrAddrQ.delete();
        wrDataQ.delete();
        img.delete();
        pulseStart();
        sendByte(8'h81, 2, ok);
        sendByte(8'h00, 2, okB);
        i_byte_valid = 1'b1;
        i_byte_data  = 8'hAA;
        waitFinish(okB);
        checks++;
        if (o_error !== 1'b1 || o_done !== 1'b0 || o_cpu_hold !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lenerr_flag error=%b done=%b hold=%b required 1 0 1",
                     o_error, o_done, o_cpu_hold);
        end
        repeat (4) @(negedge i_clk);
        i_byte_valid = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_cpu_hold !== 1'b1 || o_error !== 1'b1 || wrAddrQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL lenerr_idle busy=%b hold=%b error=%b writes=%0d required 0 1 1 0",
                     o_busy, o_cpu_hold, o_error, wrAddrQ.size());
        end
        pulseStart();
        checks++;
        if (o_error !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lenerr_clear error=%b done=%b required 0 0", o_error, o_done);
        end
        sendByte(8'h00, 0, ok);
        sendByte(8'h00, 0, okB);
        waitFinish(okB);
        checks++;
        if (o_done !== 1'b1 || o_error !== 1'b0 || o_cpu_hold !== 1'b0 || wrAddrQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL lenzero done=%b error=%b hold=%b writes=%0d required 1 0 0 0",
                     o_done, o_error, o_cpu_hold, wrAddrQ.size());
        end
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        test_reset();

        img = {32'h002081B3};
        test_load("single", 0, -1);

        img = {32'h002081B3, 32'h403202B3, 32'h00308383};
        test_load("three", 0, -1);
        test_load("gaps", 5, -1);
        test_load("start_in_data", 0, 5);

        img.delete();
        repeat (int'($urandom_range(8, 2))) img.push_back($urandom);
        test_load("random", 5, -1);

        img.delete();
        for (int i = 0; i < Depth / 4; i++) img.push_back($urandom);
        test_load("maxlen", 0, -1);

        test_length_error();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
